// File: rtl/sel_mux_reg.sv
// Registered N-channel data selector with valid/ready on both sides, illegal-select
// error flag and saturating error counter. Optional x/z select check: SEL_XZ_CHECK_EN.
module sel_mux_reg #(
    parameter int               WIDTH       = 4,
    parameter int               NCH         = 4,
    parameter int               SELW        = 2,
    parameter logic [WIDTH-1:0] DEFAULT     = '0,
    parameter bit               HOLD_ON_ERR = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [NCH*WIDTH-1:0]  datain,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      dataout,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    localparam int IW = $clog2(NCH*WIDTH);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             accept, drain, illegal;
    logic [IW-1:0]    base;
    logic [WIDTH-1:0] sel_data;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    // Out-of-range part-select only happens for illegal selects, whose data is never used.
    assign base     = IW'(sel) * IW'(WIDTH);
    assign sel_data = datain[base +: WIDTH];

`ifdef SEL_XZ_CHECK_EN
    assign illegal = (32'(sel) >= 32'(NCH)) || (^sel === 1'bx);

    always @(posedge clk) begin
        if (!rst && accept && (^sel === 1'bx))
            $display("sel_mux_reg: x/z select at time %0t, sel=%b", $time, sel);
    end
`else
    assign illegal = 32'(sel) >= 32'(NCH);
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        dataout_d   = dataout_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            if (illegal) begin
                err_d     = 1'b1;
                dataout_d = HOLD_ON_ERR ? dataout_q : DEFAULT;
                err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            end else begin
                err_d     = 1'b0;
                dataout_d = sel_data;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dataout_q   <= DEFAULT;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dataout_q   <= dataout_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dataout   = dataout_q;
    // err stays latched across a drain but is only visible with a live result.
    assign err       = err_q && out_valid_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sel_mux_reg.sv
// Bench for sel_mux_reg: three instances (4-channel default, 3-channel with DEFAULT=F
// in load and hold modes) share stimulus and are checked against a per-instance model.
module tb_sel_mux_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  sel = '0;
    logic [15:0] datain = '0;

    logic       rdy [3];
    logic       ov  [3];
    logic [3:0] dout[3];
    logic       er  [3];
    logic [7:0] cnt [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sel_mux_reg #(.WIDTH(4), .NCH(4), .SELW(2)) u_dflt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .sel(sel),
        .datain(datain), .out_valid(ov[0]), .out_ready(out_ready), .dataout(dout[0]),
        .err(er[0]), .err_cnt(cnt[0]));

    sel_mux_reg #(.WIDTH(4), .NCH(3), .SELW(2), .DEFAULT(4'hF), .HOLD_ON_ERR(1'b0)) u_err0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .sel(sel),
        .datain(datain[11:0]), .out_valid(ov[1]), .out_ready(out_ready), .dataout(dout[1]),
        .err(er[1]), .err_cnt(cnt[1]));

    sel_mux_reg #(.WIDTH(4), .NCH(3), .SELW(2), .DEFAULT(4'hF), .HOLD_ON_ERR(1'b1)) u_err1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .sel(sel),
        .datain(datain[11:0]), .out_valid(ov[2]), .out_ready(out_ready), .dataout(dout[2]),
        .err(er[2]), .err_cnt(cnt[2]));

    // Behavioural model: one held result per instance plus an error tally.
    int nch [3] = '{4, 3, 3};
    bit hold[3] = '{1'b0, 1'b0, 1'b1};
    int dflt[3] = '{0, 15, 15};
    bit mv  [3];
    int md  [3];
    bit me  [3];
    int mc  [3];

    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (rst) begin
                mv[m] = 1'b0; md[m] = dflt[m]; me[m] = 1'b0; mc[m] = 0;
            end else if (in_valid && (!mv[m] || out_ready)) begin
                if (int'(sel) >= nch[m]) begin
                    me[m] = 1'b1;
                    if (!hold[m]) md[m] = dflt[m];
                    mc[m] = (mc[m] + 1 > 255) ? 255 : mc[m] + 1;
                end else begin
                    me[m] = 1'b0;
                    md[m] = (int'(datain) >> (4 * int'(sel))) % 16;
                end
                mv[m] = 1'b1;
            end else if (mv[m] && out_ready) begin
                mv[m] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model-vs-DUT comparison every cycle, away from the clock edge.
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("in_ready[%0d]", m),  int'(rdy[m]),  int'(!mv[m] || out_ready));
            chk($sformatf("out_valid[%0d]", m), int'(ov[m]),   int'(mv[m]));
            chk($sformatf("dataout[%0d]", m),   int'(dout[m]), md[m]);
            chk($sformatf("err[%0d]", m),       int'(er[m]),   int'(me[m] && mv[m]));
            chk($sformatf("err_cnt[%0d]", m),   int'(cnt[m]),  mc[m]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with in_valid asserted.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; sel = 2'd1; datain = 16'h1234;
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst out_valid", int'(ov[0]), 0);
        chk("rst dataout", int'(dout[0]), 0);
        chk("rst dataout dflt F", int'(dout[1]), 15);
        chk("rst err_cnt", int'(cnt[0]), 0);
        chk("rst in_ready", int'(rdy[0]), 1);

        // Single transfer under backpressure.
        datain = 16'hDCBA; sel = 2'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single out_valid", int'(ov[0]), 1);
        chk("single dataout", int'(dout[0]), 12);
        chk("single in_ready low", int'(rdy[0]), 0);
        step();
        chk("single held", int'(dout[0]), 12);
        out_ready = 1'b1;
        #1;
        chk("single in_ready high", int'(rdy[0]), 1);
        step();
        chk("single drained", int'(ov[0]), 0);

        // Streaming with no bubbles.
        datain = 16'h4321; in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step();
            chk("stream out_valid", int'(ov[0]), 1);
            chk("stream dataout", int'(dout[0]), s + 1);
        end
        chk("stream illegal dflt", int'(dout[1]), 15);
        chk("stream illegal err", int'(er[1]), 1);
        chk("stream illegal cnt", int'(cnt[1]), 1);
        chk("stream hold dout", int'(dout[2]), 3);

        // Hold mode keeps the last legal value.
        datain = 16'h0050; sel = 2'd1;
        step();
        chk("hold legal", int'(dout[2]), 5);
        sel = 2'd3;
        step();
        chk("hold dout", int'(dout[2]), 5);
        chk("hold err", int'(er[2]), 1);
        chk("load dout", int'(dout[1]), 15);
        in_valid = 1'b0;
        step();
        chk("err masked after drain", int'(er[1]), 0);

        // Saturation of the error counter.
        in_valid = 1'b1; out_ready = 1'b1; sel = 2'd3;
        for (int i = 0; i < 300; i++) step();
        chk("sat cnt", int'(cnt[1]), 255);
        step(); step();
        chk("sat stays", int'(cnt[2]), 255);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("sat cleared", int'(cnt[1]), 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sel       = 2'($urandom_range(0, 3));
            datain    = 16'($urandom);
            step();
        end
        rst = 1'b0; in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
